// File: rtl/bram_readout_pkg.sv
// Shared widths and FSM state encoding for the capture-buffer read side.
package bram_readout_pkg;

    localparam int unsigned NB_ADDR_DEF   = 15;
    localparam int unsigned NB_DATA_DEF   = 14;
    localparam int unsigned MAX_COUNT_DEF = 2047;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/bram_readout.sv
// Walks BRAM addresses 0..MAX_COUNT once per start and hands each word
// downstream on a valid/ready handshake.
// The read strobe is launched on the edge that enters FETCH, or on a later
// edge if that fetch was paused. The BRAM therefore returns data during WAIT,
// and the first word is valid three cycles after the start pulse.
module bram_readout
    import bram_readout_pkg::*;
#(
    parameter int unsigned NB_ADDR   = NB_ADDR_DEF,
    parameter int unsigned NB_DATA   = NB_DATA_DEF,
    parameter int unsigned MAX_COUNT = MAX_COUNT_DEF
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_enable,
    input  logic               i_abort,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic               o_read_enable,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MAX_COUNT);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;
    logic [NB_DATA-1:0] data_q,  data_d;
    logic               valid_q, valid_d;
    logic               rden_q,  rden_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Next state, address counter, output register and strobes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        rden_d  = 1'b0;
        done_d  = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && i_enable) begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                        rden_d  = 1'b1;
                    end
                end
                ST_FETCH: begin
                    // A strobe already out this cycle means the read is in flight.
                    if (rden_q) begin
                        state_d = ST_WAIT;
                    end else if (i_enable) begin
                        rden_d = 1'b1;
                    end
                end
                ST_WAIT: begin
                    data_d  = i_read_data;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = addr_q + NB_ADDR'(1);
                            rden_d  = i_enable;
                        end
                    end
                end
                ST_DONE: begin
                    addr_d  = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            rden_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rden_q  <= rden_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_read_addr   = addr_q;
    assign o_read_enable = rden_q;
    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_bram_readout.sv
// Bench for bram_readout with an 8-word BRAM model (MAX_COUNT = 7).
module tb_bram_readout;

    localparam int unsigned NA   = 15;
    localparam int unsigned ND   = 14;
    localparam int unsigned MAXC = 7;

    logic          clock = 1'b0;
    logic          i_reset;
    logic          i_start, i_enable, i_abort, i_ready;
    logic [NA-1:0] o_read_addr;
    logic          o_read_enable;
    logic [ND-1:0] i_read_data;
    logic [ND-1:0] o_data;
    logic          o_valid, o_busy, o_done;

    logic [ND-1:0] mem [0:MAXC];

    int n_checks = 0;
    int n_err    = 0;

    bram_readout #(.NB_ADDR(NA), .NB_DATA(ND), .MAX_COUNT(MAXC)) dut (
        .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_enable(i_enable),
        .i_abort(i_abort), .o_read_addr(o_read_addr), .o_read_enable(o_read_enable),
        .i_read_data(i_read_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clock = ~clock;

    // BRAM: one-cycle registered read.
    always @(posedge clock) begin
        if (o_read_enable) i_read_data <= mem[o_read_addr[2:0]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_mem(input int unsigned base);
        for (int a = 0; a <= int'(MAXC); a++) mem[a] = ND'(base + a);
    endtask

    typedef struct {
        bit            st, en, ab, rdy;
        bit            chk_data;
        logic [ND-1:0] data;
        bit            valid, rden, busy, done;
        int unsigned   addr;
    } vec_t;

    vec_t vec [18];

    // Plays one run: accepted words must be base+0..base+MAXC in order, with a
    // single o_done the cycle after the last acceptance. Directed mode holds
    // word 3 for 5 cycles and pauses the fetch of word 2 for 4 cycles.
    task automatic run_one(input int unsigned base, input bit rnd);
        int unsigned exp_idx = 0;
        int          hold_cnt = 0;
        int          pause_cnt = 0;
        bit          done_exp = 0;
        bit          prev_hold = 0;
        logic [ND-1:0] prev_data = '0;
        bit          fin = 0;
        fill_mem(base);
        i_start = 1; i_enable = 0; i_ready = 0; i_abort = 0;
        tick();
        check("dropped_start_busy", 32'(o_busy), 0);
        i_start = 1; i_enable = 1;
        tick();
        i_start = 0;
        check("start_busy", 32'(o_busy), 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            check("done_pulse", 32'(o_done), 32'(done_exp));
            if (done_exp) fin = 1;
            if (prev_hold) begin
                check("hold_valid", 32'(o_valid), 1);
                check("hold_data", 32'(o_data), 32'(prev_data));
            end
            if (o_read_addr > NA'(MAXC)) check("addr_range", 32'(o_read_addr), MAXC);
            if (!rnd && pause_cnt > 0) begin
                check("pause_no_rden", 32'(o_read_enable), 0);
                check("pause_addr", 32'(o_read_addr), 2);
            end
            done_exp = 0;
            if (rnd) begin
                i_ready  = ($urandom % 3) != 0;
                i_enable = ($urandom % 4) != 0;
                i_start  = ($urandom % 8) == 0;
            end else begin
                i_start = (cyc == 10);
                i_ready = 1;
                if (o_valid && exp_idx == 3 && hold_cnt < 5) begin
                    i_ready = 0;
                    hold_cnt++;
                    check("bp_data", 32'(o_data), base + 3);
                    check("bp_addr", 32'(o_read_addr), 3);
                end
                if (pause_cnt > 0) begin
                    i_enable = (pause_cnt > 1) ? 1'b0 : 1'b1;
                    pause_cnt--;
                end else begin
                    i_enable = 1;
                end
                if (o_valid && i_ready && exp_idx == 1) begin
                    i_enable  = 0;
                    pause_cnt = 4;
                end
            end
            if (o_valid && i_ready) begin
                check("word_data", 32'(o_data), base + exp_idx);
                check("word_addr", 32'(o_read_addr), exp_idx);
                if (exp_idx == MAXC) done_exp = 1;
                exp_idx++;
            end
            prev_hold = o_valid && !i_ready;
            prev_data = o_data;
            if (!fin) tick();
        end
        if (!fin) begin
            n_checks++; n_err++;
            $display("FAIL run_timeout: got no o_done expected o_done within 400 cycles");
        end
        check("word_count", exp_idx, MAXC + 1);
        i_start = 0; i_enable = 1; i_ready = 0;
        tick();
        check("after_done_busy", 32'(o_busy), 0);
        check("after_done_pulse", 32'(o_done), 0);
    endtask

    initial begin
        bit found;
        i_reset = 0; i_start = 0; i_enable = 0; i_abort = 0; i_ready = 0;
        fill_mem(100);
        #12;
        check("rst_outputs", {o_read_addr, o_read_enable, o_data, o_valid, o_busy, o_done}, 0);
        i_reset = 1;
        tick();
        check("rst_idle_busy", 32'(o_busy), 0);

        // Cycle-exact vectors: start latency, backpressure, abort, dropped start, pause.
        //           st en ab rdy chk data valid rden busy done addr
        vec[0]  = '{1, 1, 0, 0, 1, 0,   0, 1, 1, 0, 0};
        vec[1]  = '{0, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0};
        vec[2]  = '{0, 1, 0, 0, 1, 100, 1, 0, 1, 0, 0};
        vec[3]  = '{0, 1, 0, 0, 1, 100, 1, 0, 1, 0, 0};
        vec[4]  = '{0, 1, 0, 1, 1, 100, 0, 1, 1, 0, 1};
        vec[5]  = '{0, 1, 0, 1, 1, 100, 0, 0, 1, 0, 1};
        vec[6]  = '{0, 1, 0, 1, 1, 101, 1, 0, 1, 0, 1};
        vec[7]  = '{0, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0};
        vec[8]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        vec[9]  = '{1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0};
        vec[10] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
        vec[11] = '{0, 0, 0, 0, 1, 100, 1, 0, 1, 0, 0};
        vec[12] = '{0, 0, 0, 1, 1, 100, 0, 0, 1, 0, 1};
        vec[13] = '{0, 0, 0, 0, 1, 100, 0, 0, 1, 0, 1};
        vec[14] = '{0, 1, 0, 0, 1, 100, 0, 1, 1, 0, 1};
        vec[15] = '{0, 1, 0, 0, 1, 100, 0, 0, 1, 0, 1};
        vec[16] = '{0, 1, 0, 0, 1, 101, 1, 0, 1, 0, 1};
        vec[17] = '{0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        for (int i = 0; i < 18; i++) begin
            i_start = vec[i].st; i_enable = vec[i].en; i_abort = vec[i].ab; i_ready = vec[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vec[i].valid));
            check($sformatf("vec%0d_rden", i), 32'(o_read_enable), 32'(vec[i].rden));
            check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vec[i].busy));
            check($sformatf("vec%0d_done", i), 32'(o_done), 32'(vec[i].done));
            check($sformatf("vec%0d_addr", i), 32'(o_read_addr), vec[i].addr);
            if (vec[i].chk_data) check($sformatf("vec%0d_data", i), 32'(o_data), 32'(vec[i].data));
        end
        i_abort = 0;

        // Directed full run: data = addr + 100.
        run_one(100, 0);

        // Abort in PRESENT of word 5, then restart from address 0.
        fill_mem(100);
        i_start = 1; i_enable = 1; i_ready = 1;
        tick();
        i_start = 0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            check("abort_no_done", 32'(o_done), 0);
            if (o_valid && o_read_addr == NA'(5)) found = 1;
            else tick();
        end
        check("abort_reached_word5", 32'(found), 1);
        check("abort_word5_data", 32'(o_data), 105);
        i_abort = 1; i_ready = 0;
        tick();
        i_abort = 0;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_valid", 32'(o_valid), 0);
        check("abort_rden", 32'(o_read_enable), 0);
        check("abort_addr", 32'(o_read_addr), 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("abort_done_quiet", 32'(o_done), 0);
            check("abort_stays_idle", 32'(o_busy), 0);
        end
        i_start = 1; i_ready = 1;
        tick();
        i_start = 0;
        tick(); tick();
        check("restart_valid", 32'(o_valid), 1);
        check("restart_data", 32'(o_data), 100);
        check("restart_addr", 32'(o_read_addr), 0);
        i_abort = 1;
        tick();
        i_abort = 0;

        // Randomized runs against the word-sequence model.
        for (int r = 0; r < 12; r++) run_one($urandom_range(0, 15000), 1);

        // Async reset while a word is presented.
        fill_mem(100);
        i_start = 1; i_enable = 1; i_ready = 0;
        tick();
        i_start = 0;
        tick(); tick();
        check("pre_reset_valid", 32'(o_valid), 1);
        #2;
        i_reset = 0;
        #1;
        check("midrun_reset_outputs", {o_read_addr, o_read_enable, o_data, o_valid, o_busy, o_done}, 0);
        tick();
        check("reset_held_outputs", {o_read_addr, o_read_enable, o_data, o_valid, o_busy, o_done}, 0);
        i_reset = 1;
        tick();
        check("post_reset_idle", 32'(o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
